// File: rtl/popcount_scheduler.sv
// popcount_scheduler: round-robin shares one bit-serial popcount engine among NREQ requesters.
// Optional rsp_balanced output (count == WIDTH/2) is enabled by defining POPCNT_BALANCE_EN.
module popcount_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [CW-1:0]         rsp_count,
    output logic                  busy
`ifdef POPCNT_BALANCE_EN
    , output logic                rsp_balanced
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
    state_t state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0] acc, idx, total;
    logic [IW-1:0] ptr, sel;
    logic [NREQ-1:0] gnt;
    // Scan from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        gnt = '0;
        sel = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt = NREQ'(1) << ((int'(ptr) + k) % NREQ);
                sel = IW'((int'(ptr) + k) % NREQ);
            end
        end
        req_ready = (state == IDLE && !reset) ? gnt : '0;
        total = acc + CW'(shreg[0]);
    end
    // ptr doubles as the latched ID of the word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            acc          <= '0;
            idx          <= '0;
            ptr          <= IW'(NREQ - 1);
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_count    <= '0;
            busy         <= 1'b0;
`ifdef POPCNT_BALANCE_EN
            rsp_balanced <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    shreg <= req_data[sel*WIDTH +: WIDTH];
                    acc   <= '0;
                    idx   <= '0;
                    ptr   <= sel;
                    state <= SCAN;
                    busy  <= 1'b1;
                end
                SCAN: begin
                    acc   <= total;
                    shreg <= shreg >> 1;
                    idx   <= idx + CW'(1);
                    if (idx == CW'(WIDTH - 1)) begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_count    <= total;
                        rsp_id       <= ptr;
`ifdef POPCNT_BALANCE_EN
                        rsp_balanced <= (total == CW'(WIDTH / 2));
`endif
                    end
                end
                RESP: if (rsp_ready) begin
                    state        <= IDLE;
                    rsp_valid    <= 1'b0;
                    busy         <= 1'b0;
`ifdef POPCNT_BALANCE_EN
                    rsp_balanced <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_scheduler.sv
// tb_popcount_scheduler: directed stimulus with a response scoreboard for popcount_scheduler.
module tb_popcount_scheduler;
    localparam int WIDTH = 8;
    logic clk = 1'b0, reset = 1'b1, rsp_ready = 1'b1;
    logic [3:0] req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0] req_ready;
    logic rsp_valid, busy;
    logic [1:0] rsp_id;
    logic [3:0] rsp_count;
`ifdef POPCNT_BALANCE_EN
    logic rsp_balanced;
`endif
    popcount_scheduler #(.NREQ(4), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
`ifdef POPCNT_BALANCE_EN
        , .rsp_balanced(rsp_balanced)
`endif
    );
    always #5 clk = ~clk;
    typedef struct packed {logic [1:0] id; logic [3:0] cnt; logic bal;} exp_t;
    exp_t q[$];
    exp_t e;
    int tests = 0, fails = 0, cyc = 0, last_acc = 0;
    logic prv_rv = 1'b0, prst = 1'b1;
    logic [3:0] pv = '0, pr = '0;
    logic [31:0] pd = '0;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic void chk(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction
    // Monitor: accept tracking, latency, scoreboard pop on handshake, requester protocol.
    always @(negedge clk) begin
        if (!reset) begin
            if (|(req_valid & req_ready)) begin
                chk("grant_onehot", int'($onehot(req_ready)), 1);
                last_acc = cyc + 1;
            end
            if (rsp_valid && !prv_rv) chk("latency", cyc - last_acc, WIDTH);
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rsp_id", int'(rsp_id), int'(e.id));
                    chk("rsp_count", int'(rsp_count), int'(e.cnt));
`ifdef POPCNT_BALANCE_EN
                    chk("rsp_balanced", int'(rsp_balanced), int'(e.bal));
`endif
                end
            end
            if (!prst)
                for (int i = 0; i < 4; i++)
                    if (pv[i] && !pr[i] && (!req_valid[i] || req_data[i*8 +: 8] != pd[i*8 +: 8]))
                        chk($sformatf("protocol_req%0d", i), 0, 1);
        end
        prv_rv = rsp_valid;
        pv = req_valid;
        pr = req_ready;
        pd = req_data;
        prst = reset;
    end
    task automatic wait_acc(input int g, output int n);
        n = 0;
        @(negedge clk);
        while (!(req_valid[g] && req_ready[g]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk($sformatf("accept_req%0d", g), 0, 1);
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", int'(n >= 500), 0);
    endtask
    task automatic single(input int r, input logic [7:0] d, input exp_t x);
        int n;
        q.push_back(x);
        req_data[r*8 +: 8] = d;
        req_valid[r] = 1'b1;
        wait_acc(r, n);
        chk("accept_first_cycle", n, 0);
        req_valid[r] = 1'b0;
        drain();
    endtask
    task automatic rr(input int cnt);
        int n, t, prev;
        prev = 0;
        req_valid = 4'hF;
        for (int k = 0; k < cnt; k++) begin
            wait_acc(k % 4, n);
            t = cyc;
            if (k == 0) chk("rr_first_grant", n, 0);
            else chk("rr_spacing", t - prev, WIDTH + 2);
            prev = t;
            if (k + 4 >= cnt) req_valid[k % 4] = 1'b0;
        end
        drain();
    endtask
    initial begin
        int n;
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_count", int'(rsp_count), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef POPCNT_BALANCE_EN
        chk("rst_balanced", int'(rsp_balanced), 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        single(0, 8'hB5, '{id: 2'd0, cnt: 4'd5, bal: 1'b0});
        single(1, 8'h00, '{id: 2'd1, cnt: 4'd0, bal: 1'b0});
        single(2, 8'hFF, '{id: 2'd2, cnt: 4'd8, bal: 1'b0});
        single(3, 8'h0F, '{id: 2'd3, cnt: 4'd4, bal: 1'b1});
        req_data = 32'hF0_07_03_01;
        q.push_back('{id: 2'd0, cnt: 4'd1, bal: 1'b0});
        q.push_back('{id: 2'd1, cnt: 4'd2, bal: 1'b0});
        q.push_back('{id: 2'd2, cnt: 4'd3, bal: 1'b0});
        q.push_back('{id: 2'd3, cnt: 4'd4, bal: 1'b1});
        q.push_back('{id: 2'd0, cnt: 4'd1, bal: 1'b0});
        rr(5);
        // Backpressure: requester 3 waits behind a stalled response from requester 1.
        rsp_ready = 1'b0;
        req_data[15:8] = 8'h38;
        q.push_back('{id: 2'd1, cnt: 4'd3, bal: 1'b0});
        req_valid[1] = 1'b1;
        wait_acc(1, n);
        req_valid[1] = 1'b0;
        req_data[31:24] = 8'h81;
        q.push_back('{id: 2'd3, cnt: 4'd2, bal: 1'b0});
        req_valid[3] = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_rsp_arrives", int'(rsp_valid), 1);
        repeat (20) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_id", int'(rsp_id), 1);
            chk("bp_rsp_count", int'(rsp_count), 3);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_complete", int'(rsp_valid), 0);
        wait_acc(3, n);
        chk("bp_next_accept", n, 0);
        req_valid[3] = 1'b0;
        drain();
        // Reset while requester 2 is being scanned: no response, priority back to 0.
        req_data[23:16] = 8'hAA;
        req_valid = 4'b0100;
        wait_acc(2, n);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rsp_valid", int'(rsp_valid), 0);
        chk("abort_req_ready", int'(req_ready), 0);
        chk("abort_rsp_count", int'(rsp_count), 0);
        chk("abort_rsp_id", int'(rsp_id), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        req_data = 32'hF0_07_03_01;
        q.push_back('{id: 2'd0, cnt: 4'd1, bal: 1'b0});
        q.push_back('{id: 2'd1, cnt: 4'd2, bal: 1'b0});
        q.push_back('{id: 2'd2, cnt: 4'd3, bal: 1'b0});
        q.push_back('{id: 2'd3, cnt: 4'd4, bal: 1'b1});
        rr(4);
        req_valid = '0;
        repeat (50) begin
            @(negedge clk);
            chk("idle_busy", int'(busy), 0);
            chk("idle_req_ready", int'(req_ready), 0);
            chk("idle_rsp_valid", int'(rsp_valid), 0);
        end
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/popcount_scheduler.md
# popcount_scheduler

Shares one bit-serial population-count engine between up to NREQ requesters. Each requester offers a WIDTH-bit word over a valid/ready handshake. A round-robin arbiter grants one word at a time; the engine counts its set bits over WIDTH cycles and returns the count, tagged with the requester ID, over a valid/ready response channel. It sits between the word-producing front-ends and the bit-balance checking logic, replacing per-requester counters with a single sequenced one.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data word width in bits (2..32)
- CW (localparam), $clog2(WIDTH+1), count width (4 for WIDTH=8)
- IW (localparam), $clog2(NREQ), requester ID width (2 for NREQ=4)

- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  per-requester word valid
- req_data  input  NREQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot grant; word i accepted on an edge where req_valid[i] & req_ready[i]
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumer ready
- rsp_id  output  IW  requester index of the result
- rsp_count  output  CW  number of 1 bits in the accepted word (0..WIDTH)
- busy  output  1  high in SCAN or RESP
- rsp_balanced  output  1  present only with POPCNT_BALANCE_EN; see Configuration

## Operation
- FSM states: IDLE, SCAN, RESP. Reset state is IDLE.
- IDLE:
  - req_ready is combinational: at most one bit high, selected round-robin from index ptr+1 upward with wrap-around, among requesters with req_valid set.
  - All req_ready bits are 0 when no request is pending.
  - On accept: load shift register with the word, clear the accumulator, clear the bit index, latch the granted ID, set ptr to the granted index, go to SCAN.
- SCAN: each cycle, accumulator += shreg[0], shreg >>= 1, bit index += 1. After WIDTH SCAN cycles, go to RESP.
- Accumulator is CW bits wide and cannot overflow, because the maximum value is WIDTH.
- RESP:
  - rsp_valid=1; rsp_id and rsp_count are held stable until rsp_ready=1.
  - On that edge, go to IDLE.
- req_ready is 0 in SCAN and RESP. There is no acceptance during RESP, even when rsp_ready=1.
- Requester protocol: req_valid must not be withdrawn, and req_data must not change, while req_valid=1 and req_ready=0. The bench flags violations; the RTL does not check them.
- ptr reset value is NREQ-1, so requester 0 has first priority after reset.
- Reset asserted mid-operation aborts the word in flight. No response is emitted for it, and ptr returns to NREQ-1.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, busy=0, rsp_balanced=0.
- Accept on edge E0. rsp_valid rises after edge E0+WIDTH, i.e. WIDTH cycles after acceptance.
- Minimum spacing between accepts is WIDTH+2 cycles: WIDTH SCAN cycles, 1 RESP cycle with rsp_ready=1, then 1 IDLE cycle.
- rsp_ready held low stalls the block in RESP indefinitely. Outputs stay constant and no request is accepted.
- busy is registered and equals (state != IDLE).

## Configuration
- POPCNT_BALANCE_EN:
  - Defined: port rsp_balanced exists. It is registered with rsp_count and is 1 exactly when rsp_count == WIDTH/2 (WIDTH must be even). It is 0 outside RESP.
  - Undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Single request: after reset, req_valid=4'b0001, data0=8'hB5. Required: accept in the first cycle; after 8 cycles rsp_valid=1 with rsp_id=0, rsp_count=5; with the macro, rsp_balanced=0.
- Extremes: data=8'h00 gives rsp_count=0; data=8'hFF gives rsp_count=8 (no wrap); data=8'h0F gives 4 and, with the macro, rsp_balanced=1.
- Round-robin fairness: all four req_valid held high, rsp_ready=1. Required grant order 0,1,2,3,0, accepts spaced exactly 10 cycles apart, and each rsp_id matching its grant.
- Backpressure: rsp_ready=0 for 20 cycles during RESP. Required: rsp_valid, rsp_id and rsp_count stay stable and req_ready stays 0; response completes on the cycle rsp_ready rises.
- Reset mid-SCAN: assert reset 3 cycles after accepting requester 2. Required: outputs return to reset values immediately with no rsp_valid pulse; the next grant, with all requesters valid, goes to requester 0.
- Idle with no requests: req_valid=0 for 50 cycles. Required: busy=0, req_ready=0, rsp_valid=0 throughout.
